adder_arb: RTL and testbench
============================

ADDER_ARB -- requirements
Module: adder_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum clk cycles to wait in either handshake phase.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: flop depth of the fn_ack_o synchronizer, minimum 2.
REQ-004 SHALL have ports:
- clk  in  1  single clock, all flops on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester operation request.
- req_ready  out  2  one-hot, 1-cycle grant; the operands are captured on this cycle.
- req_a, req_b  in  2xWIDTH  per-requester operands.
- req_cin  in  2  per-requester carry-in.
- rsp_valid  out  2  one-hot, 1-cycle result strobe to the granted requester.
- rsp_sum  out  WIDTH  binary sum.
- rsp_cout  out  1  binary carry-out.
- rsp_err  out  1  qualifies rsp_valid; 1 = timeout or invalid rail code.
- fn_rst  out  1  active-high reset to the dual-rail adder.
- fn_a, fn_b  out  WIDTHx2  dual-rail operands.
- fn_c_in  out  2  dual-rail carry-in.
- fn_ack_i  out  1  consumer acknowledge to the adder.
- fn_ack_o  in  1  adder acknowledge; asynchronous to clk.
- fn_s  in  WIDTHx2  dual-rail sum.
- fn_c_out  in  2  dual-rail carry-out.

Function
REQ-005 SHALL use the dual-rail code per bit as follows: 2'b10 = logic 1, 2'b01 = logic 0, 2'b00 = NULL, 2'b11 = invalid.
REQ-006 SHALL synchronize fn_ack_o through SYNC_STAGES flops before any use; ack_s denotes the synchronized value.
REQ-007 SHALL implement the FSM states IDLE, DATA, CAPT, NULL, RSP and RECOV.
REQ-008 In IDLE with any req_valid set, the block SHALL select a requester round-robin, assert its req_ready for 1 cycle, register its operands, and enter DATA.
REQ-009 Round-robin priority SHALL go to the requester not granted last; after reset, requester 0 has priority.
REQ-010 In DATA, fn_a/fn_b/fn_c_in SHALL present the encoded registered operands with fn_ack_i=0; ack_s=1 SHALL cause entry to CAPT.
REQ-011 In CAPT, the block SHALL register the fn_s/fn_c_out decodes, set the error flag if any rail pair is not one-hot, drive fn_ack_i=1, and enter NULL the next cycle.
REQ-012 In NULL, all fn_a/fn_b/fn_c_in rails SHALL be 0 with fn_ack_i=1; ack_s=0 SHALL cause entry to RSP with fn_ack_i=0.
REQ-013 In RSP, the block SHALL pulse rsp_valid[granted] for 1 cycle with rsp_sum/rsp_cout/rsp_err valid, then enter IDLE.
- rsp_sum/rsp_cout SHALL hold their values until the next RSP.
REQ-014 A counter SHALL clear on entry to DATA and on entry to NULL, and SHALL increment each cycle in those states.
- When the count reaches TIMEOUT, the block SHALL set the error flag and enter RECOV.
REQ-015 In RECOV, fn_rst SHALL be 1 and all fn outputs NULL/0 for 4 cycles, after which the block SHALL enter RSP with rsp_err=1 and rsp_sum=0.
REQ-016 A new grant SHALL NOT occur before the RSP cycle of the previous operation; the minimum grant-to-grant spacing is 4+2*SYNC_STAGES cycles.
REQ-017 req_valid SHALL be ignored outside IDLE.
REQ-018 With both req_valid set in IDLE, the block SHALL grant exactly one requester.
REQ-019 No grant SHALL occur in the same cycle as rsp_valid.
REQ-020 rsp_cout SHALL be the true WIDTH+1-bit carry of a+b+cin; there SHALL be no saturation.

Reset
REQ-021 While rst=0, the block SHALL force state IDLE, req_ready=0, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_err=0, fn_a/fn_b/fn_c_in all 0 (NULL), fn_ack_i=0, fn_rst=1, counter=0, synchronizer=0, and priority=requester 0.
REQ-022 Reset asserted mid-operation SHALL abort the operation with no rsp_valid.
REQ-023 fn_rst SHALL deassert on the first clk edge after rst rises.

Verification
REQ-024 Scenario: WIDTH=8, req0 a=0x0F b=0x01 cin=0 -> rsp_valid=2'b01, sum=0x10, cout=0, err=0.
REQ-025 Scenario: req1 a=0xFF b=0x01 cin=1 -> rsp_valid=2'b10, sum=0x01, cout=1, err=0.
REQ-026 Scenario: both req_valid held from reset for 3 operations -> grant order 0,1,0, with one rsp_valid per grant.
REQ-027 Scenario: adder model never raises fn_ack_o -> rsp_err=1 and sum=0 after TIMEOUT+4+1 cycles, with fn_rst high for exactly 4 cycles.
REQ-028 Scenario: model returns fn_s[3]=2'b11 -> rsp_err=1 and operation completes normally.
REQ-029 Scenario: rst=0 while in NULL -> all fn rails 0, fn_rst=1 immediately, no rsp_valid; the next request completes correctly.

Source files
------------

// File: rtl/adder_arb_if.sv
// Signal bundle between adder_arb, its two requesters and the external dual-rail adder.
// slave is the arbiter's view; master is the view of the requesters plus the adder.
interface adder_arb_if #(
    parameter int WIDTH = 8
);
    logic [1:0]                  req_valid;
    logic [1:0]                  req_ready;
    logic [1:0][WIDTH-1:0]       req_a;
    logic [1:0][WIDTH-1:0]       req_b;
    logic [1:0]                  req_cin;
    logic [1:0]                  rsp_valid;
    logic [WIDTH-1:0]            rsp_sum;
    logic                        rsp_cout;
    logic                        rsp_err;
    logic                        fn_rst;
    logic [WIDTH-1:0][1:0]       fn_a;
    logic [WIDTH-1:0][1:0]       fn_b;
    logic [1:0]                  fn_c_in;
    logic                        fn_ack_i;
    logic                        fn_ack_o;
    logic [WIDTH-1:0][1:0]       fn_s;
    logic [1:0]                  fn_c_out;

    modport slave (
        input  req_valid, req_a, req_b, req_cin,
        input  fn_ack_o, fn_s, fn_c_out,
        output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_err,
        output fn_rst, fn_a, fn_b, fn_c_in, fn_ack_i
    );

    modport master (
        output req_valid, req_a, req_b, req_cin,
        output fn_ack_o, fn_s, fn_c_out,
        input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_err,
        input  fn_rst, fn_a, fn_b, fn_c_in, fn_ack_i
    );
endinterface

// File: rtl/adder_arb.sv
// Two-requester round-robin front end for a self-timed dual-rail adder: encodes operands,
// runs the four-phase DATA/NULL handshake against a synchronized ack, and recovers on timeout.
module adder_arb #(
    parameter int WIDTH       = 8,
    parameter int TIMEOUT     = 255,
    parameter int SYNC_STAGES = 2    // minimum 2
) (
    input  logic       clk,
    input  logic       rst,
    adder_arb_if.slave bus
);
    localparam int CW = ($clog2(TIMEOUT + 1) > 2) ? $clog2(TIMEOUT + 1) : 2;
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] RECOV_LAST   = CW'(3);
    localparam logic [1:0]    RAIL_ONE     = 2'b10;
    localparam logic [1:0]    RAIL_ZERO    = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_CAPT,
        S_NULL,
        S_RSP,
        S_RECOV
    } state_t;

    typedef logic [WIDTH-1:0][1:0] rail_t;

    function automatic rail_t encode(input logic [WIDTH-1:0] v);
        rail_t r;
        for (int i = 0; i < WIDTH; i++) r[i] = v[i] ? RAIL_ONE : RAIL_ZERO;
        return r;
    endfunction

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
    logic                   last_q, last_d;
    logic                   sel;
    logic [1:0]             grant;
    logic [1:0]             gnt_q, gnt_d;
    rail_t                  fn_a_q, fn_a_d, fn_b_q, fn_b_d;
    logic [1:0]             fn_cin_q, fn_cin_d;
    logic                   fn_ack_q, fn_ack_d;
    logic                   fn_rst_q, fn_rst_d;
    logic [WIDTH-1:0]       sum_q, sum_d;
    logic                   cout_q, cout_d;
    logic                   err_q, err_d;
    logic [1:0]             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]       rsp_sum_q, rsp_sum_d;
    logic                   rsp_cout_q, rsp_cout_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [WIDTH-1:0]       s_bits;
    logic                   rail_bad;

    // fn_ack_o comes from the self-timed domain and is only ever used through ack_s.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '0;
        else      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.fn_ack_o};
    end

    assign ack_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        rail_bad = (bus.fn_c_out[1] == bus.fn_c_out[0]);
        for (int i = 0; i < WIDTH; i++) begin
            s_bits[i] = bus.fn_s[i][1];
            rail_bad  = rail_bad | (bus.fn_s[i][1] == bus.fn_s[i][0]);
        end
    end

    always_comb begin
        if (bus.req_valid == 2'b11) sel = ~last_q;
        else                        sel = bus.req_valid[1];
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned
    // (which would infer a latch).
    always_comb begin
        state_d = state_q;
        grant   = '0;
        last_d  = last_q;
        gnt_d   = gnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                // fn_rst_q is still high for one cycle after reset release; no grant then.
                if (!fn_rst_q && (bus.req_valid != 2'b00)) begin
                    grant   = sel ? 2'b10 : 2'b01;
                    gnt_d   = grant;
                    last_d  = sel;
                    err_d   = 1'b0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (ack_s)                      state_d = S_CAPT;
                else if (cnt_q == TIMEOUT_LAST) state_d = S_RECOV;
            end
            S_CAPT: begin
                sum_d   = s_bits;
                cout_d  = bus.fn_c_out[1];
                err_d   = err_q | rail_bad;
                state_d = S_NULL;
            end
            S_NULL: begin
                if (!ack_s)                     state_d = S_RSP;
                else if (cnt_q == TIMEOUT_LAST) state_d = S_RECOV;
            end
            S_RSP:   state_d = S_IDLE;
            S_RECOV: if (cnt_q == RECOV_LAST) state_d = S_RSP;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_RECOV && state_q != S_RECOV) begin
            err_d  = 1'b1;
            sum_d  = '0;
            cout_d = 1'b0;
        end

        cnt_d = '0;
        if (state_d == state_q && state_q inside {S_DATA, S_NULL, S_RECOV})
            cnt_d = cnt_q + CW'(1);

        // Outputs are registered from the next state so the adder never sees decode glitches.
        fn_a_d   = '0;
        fn_b_d   = '0;
        fn_cin_d = '0;
        if (state_d inside {S_DATA, S_CAPT}) begin
            if (state_q == S_IDLE) begin
                fn_a_d   = encode(bus.req_a[sel]);
                fn_b_d   = encode(bus.req_b[sel]);
                fn_cin_d = bus.req_cin[sel] ? RAIL_ONE : RAIL_ZERO;
            end else begin
                fn_a_d   = fn_a_q;
                fn_b_d   = fn_b_q;
                fn_cin_d = fn_cin_q;
            end
        end
        fn_ack_d = state_d inside {S_CAPT, S_NULL};
        fn_rst_d = (state_d == S_RECOV);

        rsp_valid_d = '0;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_err_d   = rsp_err_q;
        if (state_d == S_RSP) begin
            rsp_valid_d = gnt_q;
            rsp_sum_d   = sum_d;
            rsp_cout_d  = cout_d;
            rsp_err_d   = err_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            gnt_q       <= '0;
            fn_a_q      <= '0;
            fn_b_q      <= '0;
            fn_cin_q    <= '0;
            fn_ack_q    <= 1'b0;
            fn_rst_q    <= 1'b1;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            fn_a_q      <= fn_a_d;
            fn_b_q      <= fn_b_d;
            fn_cin_q    <= fn_cin_d;
            fn_ack_q    <= fn_ack_d;
            fn_rst_q    <= fn_rst_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_cout  = rsp_cout_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.fn_rst    = fn_rst_q;
    assign bus.fn_a      = fn_a_q;
    assign bus.fn_b      = fn_b_q;
    assign bus.fn_c_in   = fn_cin_q;
    assign bus.fn_ack_i  = fn_ack_q;

endmodule

// File: tb/tb_adder_arb.sv
// Bench for adder_arb: behavioural dual-rail adder, arithmetic/round-robin reference model.
module tb_adder_arb;
    localparam int WIDTH = 8;
    localparam int TO    = 40;
    localparam int SYNC  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   mode = 0;          // 0 normal, 1 adder never acks, 2 adder corrupts sum bit 3
    logic last_gnt = 1'b1;   // requester granted last; 1 after reset so requester 0 wins

    adder_arb_if #(.WIDTH(WIDTH)) bus ();

    adder_arb #(.WIDTH(WIDTH), .TIMEOUT(TO), .SYNC_STAGES(SYNC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] exp_grant(input logic [1:0] v, input logic last);
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        return v;
    endfunction

    function automatic bit all_data(input logic [7:0][1:0] a, input logic [7:0][1:0] b,
                                    input logic [1:0] c);
        for (int i = 0; i < 8; i++)
            if (a[i][0] == a[i][1] || b[i][0] == b[i][1]) return 1'b0;
        return c[0] != c[1];
    endfunction

    // Self-timed adder: evaluates on DATA when ack_i is low, returns to NULL on NULL with ack_i high.
    initial begin : adder_model
        logic [8:0] full;
        logic [7:0] av, bv;
        bus.fn_ack_o = 1'b0;
        bus.fn_s     = '0;
        bus.fn_c_out = '0;
        forever begin
            #1;
            if (bus.fn_rst === 1'b1) begin
                bus.fn_ack_o = 1'b0;
                bus.fn_s     = '0;
                bus.fn_c_out = '0;
            end else if (!bus.fn_ack_o && bus.fn_ack_i === 1'b0 && mode != 1 &&
                         all_data(bus.fn_a, bus.fn_b, bus.fn_c_in)) begin
                for (int i = 0; i < 8; i++) begin
                    av[i] = bus.fn_a[i][1];
                    bv[i] = bus.fn_b[i][1];
                end
                full = 9'(av) + 9'(bv) + 9'(bus.fn_c_in[1]);
                for (int i = 0; i < 8; i++) bus.fn_s[i] = full[i] ? 2'b10 : 2'b01;
                if (mode == 2) bus.fn_s[3] = 2'b11;
                bus.fn_c_out = full[8] ? 2'b10 : 2'b01;
                bus.fn_ack_o = 1'b1;
            end else if (bus.fn_ack_o && bus.fn_ack_i === 1'b1 && bus.fn_a == '0 &&
                         bus.fn_b == '0 && bus.fn_c_in == 2'b00) begin
                bus.fn_s     = '0;
                bus.fn_c_out = '0;
                bus.fn_ack_o = 1'b0;
            end
        end
    end

    // Drives one request and returns what the DUT did; comparisons live in the callers.
    task automatic run_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, output logic [1:0] gnt, output logic [1:0] rv,
                          output logic [7:0] sum, output logic cout, output logic err,
                          output int lat, output int rst_cycles, output bit hung);
        int n;
        hung = 1'b0; gnt = '0; rv = '0; sum = '0; cout = 1'b0; err = 1'b0;
        lat = 0; rst_cycles = 0;
        @(negedge clk);
        bus.req_valid[idx] = 1'b1;
        bus.req_a[idx]     = a;
        bus.req_b[idx]     = b;
        bus.req_cin[idx]   = cin;
        #1;
        n = 0;
        while (bus.req_ready == 2'b00 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        gnt = bus.req_ready;
        if (gnt == 2'b00) begin
            hung = 1'b1;
            bus.req_valid[idx] = 1'b0;
            return;
        end
        @(negedge clk);
        bus.req_valid[idx] = 1'b0;
        lat = 1;
        while (bus.rsp_valid == 2'b00 && lat < TO + 20) begin
            if (bus.fn_rst) rst_cycles++;
            @(negedge clk); lat++;
        end
        if (bus.rsp_valid == 2'b00) begin
            hung = 1'b1;
            return;
        end
        rv   = bus.rsp_valid;
        sum  = bus.rsp_sum;
        cout = bus.rsp_cout;
        err  = bus.rsp_err;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_a = '1; bus.req_b = '1; bus.req_cin = 2'b11;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (bus.req_ready !== 2'b00) begin n_err++; $display("FAIL rst_req_ready: got %b want 00", bus.req_ready); end
        n_cmp++; if (bus.rsp_valid !== 2'b00) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 00", bus.rsp_valid); end
        n_cmp++; if ({bus.rsp_cout, bus.rsp_sum, bus.rsp_err} !== 10'h0) begin n_err++; $display("FAIL rst_rsp_data: got %h want 000", {bus.rsp_cout, bus.rsp_sum, bus.rsp_err}); end
        n_cmp++; if ({bus.fn_a, bus.fn_b, bus.fn_c_in} !== '0) begin n_err++; $display("FAIL rst_fn_rails: got %h want 0", {bus.fn_a, bus.fn_b, bus.fn_c_in}); end
        n_cmp++; if (bus.fn_ack_i !== 1'b0) begin n_err++; $display("FAIL rst_fn_ack_i: got %b want 0", bus.fn_ack_i); end
        n_cmp++; if (bus.fn_rst !== 1'b1) begin n_err++; $display("FAIL rst_fn_rst: got %b want 1", bus.fn_rst); end
        @(negedge clk);
        bus.req_valid = 2'b00;
        rst = 1'b1;
        last_gnt = 1'b1;
        #1;
        n_cmp++; if (bus.fn_rst !== 1'b1) begin n_err++; $display("FAIL rst_fn_rst_hold: got %b want 1", bus.fn_rst); end
        @(posedge clk); #1;
        n_cmp++; if (bus.fn_rst !== 1'b0) begin n_err++; $display("FAIL rst_fn_rst_release: got %b want 0", bus.fn_rst); end
    endtask

    task automatic test_ops();
        logic [1:0] g, rv, eg;
        logic [7:0] s, a, b;
        logic       co, er, ci;
        logic [8:0] e;
        int         lat, rc, idx;
        bit         hung;
        for (int k = 0; k < 18; k++) begin
            if (k == 0) begin
                idx = 0; a = 8'h0F; b = 8'h01; ci = 1'b0;
            end else if (k == 1) begin
                idx = 1; a = 8'hFF; b = 8'h01; ci = 1'b1;
            end else begin
                idx = int'($urandom_range(0, 1));
                a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
            end
            e  = 9'(a) + 9'(b) + 9'(ci);
            eg = exp_grant(idx != 0 ? 2'b10 : 2'b01, last_gnt);
            run_op(idx, a, b, ci, g, rv, s, co, er, lat, rc, hung);
            last_gnt = (eg == 2'b10);
            n_cmp++; if (hung || g !== eg) begin n_err++; $display("FAIL op%0d_grant: got %b want %b (hung=%0d)", k, g, eg, hung); end
            n_cmp++; if (rv !== eg) begin n_err++; $display("FAIL op%0d_rsp_valid: got %b want %b", k, rv, eg); end
            n_cmp++; if ({co, s} !== e) begin n_err++; $display("FAIL op%0d_sum: got %h want %h", k, {co, s}, e); end
            n_cmp++; if (er !== 1'b0) begin n_err++; $display("FAIL op%0d_err: got %b want 0", k, er); end
            n_cmp++; if (lat < 4 + 2 * SYNC) begin n_err++; $display("FAIL op%0d_spacing: got %0d want >= %0d", k, lat, 4 + 2 * SYNC); end
            @(negedge clk);
            n_cmp++; if (bus.rsp_valid !== 2'b00) begin n_err++; $display("FAIL op%0d_rsp_pulse: got %b want 00", k, bus.rsp_valid); end
            n_cmp++; if ({bus.rsp_cout, bus.rsp_sum} !== e) begin n_err++; $display("FAIL op%0d_sum_hold: got %h want %h", k, {bus.rsp_cout, bus.rsp_sum}, e); end
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] a [2];
        logic [7:0] b [2];
        logic       ci [2];
        logic [1:0] g, eg;
        logic [8:0] e;
        int         n, gi, prev_cyc;
        rst = 1'b0;
        bus.req_valid = 2'b11;
        for (int i = 0; i < 2; i++) begin
            a[i] = 8'($urandom); b[i] = 8'($urandom); ci[i] = 1'($urandom);
            bus.req_a[i] = a[i]; bus.req_b[i] = b[i]; bus.req_cin[i] = ci[i];
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        last_gnt = 1'b1;
        prev_cyc = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n = 0;
            while (bus.req_ready == 2'b00 && n < 40) begin
                @(negedge clk); #1; n++;
            end
            g  = bus.req_ready;
            eg = exp_grant(2'b11, last_gnt);
            n_cmp++; if (g !== eg) begin n_err++; $display("FAIL rr%0d_grant: got %b want %b", k, g, eg); end
            if (g == 2'b00) break;
            if (k > 0) begin
                n_cmp++; if (cyc - prev_cyc < 4 + 2 * SYNC) begin n_err++; $display("FAIL rr%0d_spacing: got %0d want >= %0d", k, cyc - prev_cyc, 4 + 2 * SYNC); end
            end
            prev_cyc = cyc;
            gi = (eg == 2'b10) ? 1 : 0;
            last_gnt = (eg == 2'b10);
            e = 9'(a[gi]) + 9'(b[gi]) + 9'(ci[gi]);
            @(negedge clk);
            n_cmp++; if (bus.req_ready !== 2'b00) begin n_err++; $display("FAIL rr%0d_ready_pulse: got %b want 00", k, bus.req_ready); end
            a[gi] = 8'($urandom); b[gi] = 8'($urandom); ci[gi] = 1'($urandom);
            bus.req_a[gi] = a[gi]; bus.req_b[gi] = b[gi]; bus.req_cin[gi] = ci[gi];
            n = 0;
            while (bus.rsp_valid == 2'b00 && n < 40) begin
                @(negedge clk); n++;
            end
            n_cmp++; if (bus.rsp_valid !== eg) begin n_err++; $display("FAIL rr%0d_rsp_valid: got %b want %b", k, bus.rsp_valid, eg); end
            n_cmp++; if ({bus.rsp_cout, bus.rsp_sum} !== e) begin n_err++; $display("FAIL rr%0d_sum: got %h want %h", k, {bus.rsp_cout, bus.rsp_sum}, e); end
            #1;
            n_cmp++; if (bus.req_ready !== 2'b00) begin n_err++; $display("FAIL rr%0d_grant_during_rsp: got %b want 00", k, bus.req_ready); end
            @(negedge clk);
        end
        bus.req_valid = 2'b00;
    endtask

    task automatic test_timeout();
        logic [1:0] g, rv, eg;
        logic [7:0] s, a, b;
        logic       co, er, ci;
        logic [8:0] e;
        int         lat, rc;
        bit         hung;
        a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
        eg = exp_grant(2'b01, last_gnt);
        mode = 1;
        run_op(0, a, b, ci, g, rv, s, co, er, lat, rc, hung);
        mode = 0;
        last_gnt = (eg == 2'b10);
        n_cmp++; if (hung || rv !== eg) begin n_err++; $display("FAIL to_rsp_valid: got %b want %b (hung=%0d)", rv, eg, hung); end
        n_cmp++; if (er !== 1'b1) begin n_err++; $display("FAIL to_err: got %b want 1", er); end
        n_cmp++; if (s !== 8'h00) begin n_err++; $display("FAIL to_sum: got %h want 00", s); end
        n_cmp++; if (lat !== TO + 5) begin n_err++; $display("FAIL to_latency: got %0d want %0d", lat, TO + 5); end
        n_cmp++; if (rc !== 4) begin n_err++; $display("FAIL to_fn_rst_cycles: got %0d want 4", rc); end
        a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
        e = 9'(a) + 9'(b) + 9'(ci);
        eg = exp_grant(2'b10, last_gnt);
        run_op(1, a, b, ci, g, rv, s, co, er, lat, rc, hung);
        last_gnt = (eg == 2'b10);
        n_cmp++; if (hung || rv !== eg) begin n_err++; $display("FAIL to_next_rsp_valid: got %b want %b", rv, eg); end
        n_cmp++; if ({co, s, er} !== {e, 1'b0}) begin n_err++; $display("FAIL to_next_result: got %h want %h", {co, s, er}, {e, 1'b0}); end
    endtask

    task automatic test_invalid_rail();
        logic [1:0] g, rv, eg;
        logic [7:0] s, a, b;
        logic       co, er, ci;
        logic [8:0] e;
        int         lat, rc, idx;
        bit         hung;
        idx = int'($urandom_range(0, 1));
        a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
        e = 9'(a) + 9'(b) + 9'(ci);
        eg = exp_grant(idx != 0 ? 2'b10 : 2'b01, last_gnt);
        mode = 2;
        run_op(idx, a, b, ci, g, rv, s, co, er, lat, rc, hung);
        mode = 0;
        last_gnt = (eg == 2'b10);
        n_cmp++; if (hung || rv !== eg) begin n_err++; $display("FAIL inv_rsp_valid: got %b want %b", rv, eg); end
        n_cmp++; if (er !== 1'b1) begin n_err++; $display("FAIL inv_err: got %b want 1", er); end
        n_cmp++; if (lat >= TO) begin n_err++; $display("FAIL inv_no_timeout: got latency %0d want < %0d", lat, TO); end
        n_cmp++; if ({co, s & 8'hF7} !== {e[8], e[7:0] & 8'hF7}) begin n_err++; $display("FAIL inv_other_bits: got %h want %h", {co, s & 8'hF7}, {e[8], e[7:0] & 8'hF7}); end
        a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
        e = 9'(a) + 9'(b) + 9'(ci);
        eg = exp_grant(2'b01, last_gnt);
        run_op(0, a, b, ci, g, rv, s, co, er, lat, rc, hung);
        last_gnt = (eg == 2'b10);
        n_cmp++; if (hung || {co, s, er} !== {e, 1'b0}) begin n_err++; $display("FAIL inv_next_result: got %h want %h", {co, s, er}, {e, 1'b0}); end
    endtask

    task automatic test_reset_in_null();
        logic [1:0] g, rv, eg;
        logic [7:0] s, a, b;
        logic       co, er, ci;
        logic [8:0] e;
        int         lat, rc, n;
        bit         hung, saw;
        @(negedge clk);
        bus.req_valid[0] = 1'b1;
        bus.req_a[0] = 8'($urandom); bus.req_b[0] = 8'($urandom); bus.req_cin[0] = 1'($urandom);
        #1;
        n = 0;
        while (bus.req_ready == 2'b00 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        n = 0;
        while (!(bus.fn_ack_i === 1'b1 && bus.fn_a === '0) && n < 40) begin
            @(negedge clk); n++;
        end
        n_cmp++; if (n >= 40) begin n_err++; $display("FAIL rn_reach_null: got timeout want NULL phase within 40 cycles"); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if ({bus.fn_a, bus.fn_b, bus.fn_c_in} !== '0) begin n_err++; $display("FAIL rn_fn_rails: got %h want 0", {bus.fn_a, bus.fn_b, bus.fn_c_in}); end
        n_cmp++; if (bus.fn_rst !== 1'b1) begin n_err++; $display("FAIL rn_fn_rst: got %b want 1", bus.fn_rst); end
        n_cmp++; if (bus.fn_ack_i !== 1'b0) begin n_err++; $display("FAIL rn_fn_ack_i: got %b want 0", bus.fn_ack_i); end
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.rsp_valid !== 2'b00) saw = 1'b1;
        end
        rst = 1'b1;
        last_gnt = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid !== 2'b00) saw = 1'b1;
        end
        n_cmp++; if (saw) begin n_err++; $display("FAIL rn_no_rsp: got rsp_valid pulse want none"); end
        a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
        e = 9'(a) + 9'(b) + 9'(ci);
        eg = exp_grant(2'b10, last_gnt);
        run_op(1, a, b, ci, g, rv, s, co, er, lat, rc, hung);
        last_gnt = (eg == 2'b10);
        n_cmp++; if (hung || rv !== eg) begin n_err++; $display("FAIL rn_next_rsp_valid: got %b want %b", rv, eg); end
        n_cmp++; if ({co, s, er} !== {e, 1'b0}) begin n_err++; $display("FAIL rn_next_result: got %h want %h", {co, s, er}, {e, 1'b0}); end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cin   = '0;
        test_reset();
        test_ops();
        test_round_robin();
        test_timeout();
        test_invalid_rail();
        test_reset_in_null();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
